// File: rtl/logic_alu_seq.sv
// logic_alu_seq: registered N-bit ALU with valid/ready handshakes on both sides.
// Single-cycle logic/add/sub ops; shifts move one bit per clock through EXEC.
// One operation in flight; result and flags are held in DONE until consumed.
module logic_alu_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_y;
  logic             r_c;
  logic             r_v;
  logic             r_z;
  logic             r_n;

  logic             w_accept;
  logic             w_is_shift;
  logic [CNT_W-1:0] w_cnt_init;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_res_c;
  logic             w_res_v;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_sh_bit;

  assign in_ready   = (r_state == IDLE) && rst_n;
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = (s[2:1] == 2'b11);
  assign out_valid  = (r_state == DONE);
  assign y          = r_y;
  assign c          = r_c;
  assign v          = r_v;
  assign z          = r_z;
  assign n          = r_n;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Shift amount clamped to WIDTH: beyond that every bit is already shifted out.
  always_comb begin
    w_cnt_init = CNT_W'(WIDTH);
    if (b < WIDTH'(WIDTH)) w_cnt_init = CNT_W'(b);
  end

  // Single-cycle result; shift ops land here only for a zero shift amount (y=a).
  always_comb begin
    w_res   = a;
    w_res_c = 1'b0;
    w_res_v = 1'b0;
    case (s)
      3'b000: w_res = a & b;
      3'b001: w_res = a | b;
      3'b010: w_res = a ^ b;
      3'b011: w_res = ~a;
      3'b100: begin
        w_res   = w_sum[WIDTH-1:0];
        w_res_c = w_sum[WIDTH];
        w_res_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b101: begin
        w_res   = w_diff[WIDTH-1:0];
        w_res_c = w_diff[WIDTH];
        w_res_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: w_res = a;
    endcase
  end

  // One-bit shift step; r_dir=1 is logical right, 0 is left.
  always_comb begin
    w_sh_nxt = r_sh << 1;
    w_sh_bit = r_sh[WIDTH-1];
    if (r_dir) begin
      w_sh_nxt = r_sh >> 1;
      w_sh_bit = r_sh[0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (w_is_shift && (w_cnt_init != '0)) w_state_nxt = EXEC;
        else                                  w_state_nxt = DONE;
      end
      EXEC: if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift progression and result/flag registers.
  // The shifted-out bit goes straight to c on the final step, so c, like y,
  // only changes when a result completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
      r_y   <= '0;
      r_c   <= 1'b0;
      r_v   <= 1'b0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      if (w_is_shift) begin
        r_sh  <= a;
        r_cnt <= w_cnt_init;
        r_dir <= s[0];
      end
      if (!w_is_shift || (w_cnt_init == '0)) begin
        r_y <= w_res;
        r_c <= w_res_c;
        r_v <= w_res_v;
        r_z <= (w_res == '0);
        r_n <= w_res[WIDTH-1];
      end
    end else if (r_state == EXEC) begin
      r_sh  <= w_sh_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_y <= w_sh_nxt;
        r_c <= w_sh_bit;
        r_v <= 1'b0;
        r_z <= (w_sh_nxt == '0);
        r_n <= w_sh_nxt[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_logic_alu_seq.sv
module tb_logic_alu_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] s;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y;
  logic       c;
  logic       v;
  logic       z;
  logic       n;
  logic       out_valid;
  logic       out_ready;

  logic_alu_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .c(c), .v(v), .z(z), .n(n),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [7:0] res;   // {y, c, v, z, n}
    int         cyc;   // cycle count at which out_valid must first be seen
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one op; expected y/c/v/z/n and edges-after-accept latency are hand-computed.
  task automatic issue(input string name, input logic [2:0] op, input logic [3:0] av,
                       input logic [3:0] bv, input logic [3:0] ey, input logic ec,
                       input logic ev, input logic ez, input logic en, input int lat);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: in_ready never rose (timeout)", name);
    end else begin
      a = av; b = bv; s = op; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e.res  = {ey, ec, ev, ez, en};
      e.cyc  = cyc + lat;
      e.name = name;
      q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: result not drained (timeout), pending=%0d", name, q.size());
    end
  endtask

  // Monitor: pops the scoreboard when a result appears and checks it is held while stalled.
  logic       prev_valid = 1'b0;
  logic [7:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got y=%b with empty scoreboard", y);
        end else begin
          e = q.pop_front();
          chk({e.name, "_res"}, {24'd0, y, c, v, z, n}, {24'd0, e.res});
          chk({e.name, "_lat"}, cyc, e.cyc);
          held = e.res;
        end
      end else if (out_valid && prev_valid) begin
        chk("hold_stable", {24'd0, y, c, v, z, n}, {24'd0, held});
      end
      if (out_valid) chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
      prev_valid = out_valid;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; s = '0;

    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 4'($urandom); b = 4'($urandom); s = 3'($urandom);
      in_valid = 1'b1; out_ready = 1'($urandom);
      chk("rst_y", {28'd0, y}, 32'd0);
      chk("rst_flags", {28'd0, c, v, z, n}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // AND with explicit handshake timing.
    issue("and", 3'b000, 4'b1010, 4'b0110, 4'b0010, 0, 0, 0, 0, 0);
    chk("and_out_valid", {31'd0, out_valid}, 32'd1);
    chk("and_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("and_after_out_valid", {31'd0, out_valid}, 32'd0);
    chk("and_after_in_ready", {31'd0, in_ready}, 32'd1);
    drain("and");

    // Logic and arithmetic vectors.
    issue("or",     3'b001, 4'b1010, 4'b0101, 4'b1111, 0, 0, 0, 1, 0);
    issue("not",    3'b011, 4'b0101, 4'b0000, 4'b1010, 0, 0, 0, 1, 0);
    issue("add_ov", 3'b100, 4'b0111, 4'b0001, 4'b1000, 0, 1, 0, 1, 0);
    issue("sub_bw", 3'b101, 4'b0011, 4'b0101, 4'b1110, 1, 0, 0, 1, 0);
    issue("add_cz", 3'b100, 4'b1111, 4'b0001, 4'b0000, 1, 0, 1, 0, 0);
    issue("sub_ov", 3'b101, 4'b1000, 4'b0001, 4'b0111, 0, 1, 0, 0, 0);
    drain("alu");

    // Shifts: latency equals shift amount, clamped to WIDTH.
    issue("shl3",   3'b110, 4'b1011, 4'd3, 4'b1000, 1, 0, 0, 1, 3);
    issue("shr7",   3'b111, 4'b1000, 4'd7, 4'b0000, 1, 0, 1, 0, 4);
    issue("shl0",   3'b110, 4'b1011, 4'd0, 4'b1011, 0, 0, 0, 1, 0);
    issue("shr1",   3'b111, 4'b1011, 4'd1, 4'b0101, 1, 0, 0, 0, 1);
    issue("shl4",   3'b110, 4'b0110, 4'd4, 4'b0000, 0, 0, 1, 0, 4);
    drain("shift");

    // Backpressure: result held, no accept while stalled.
    out_ready = 1'b0;
    issue("xor", 3'b010, 4'b1100, 4'b1010, 4'b0110, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; s = 3'b100; a = 4'($urandom); b = 4'($urandom);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    drain("bp");

    // Reset in the middle of a shift, then a fresh op.
    issue("shr_abort", 3'b111, 4'b1111, 4'd4, 4'b0000, 1, 0, 1, 0, 4);
    @(posedge clk);
    @(posedge clk);
    #2;
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y", {28'd0, y}, 32'd0);
    chk("mid_rst_flags", {28'd0, c, v, z, n}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    issue("add_after_rst", 3'b100, 4'b0010, 4'b0011, 4'b0101, 0, 0, 0, 0, 0);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
